// File: rtl/wb_sram_responder_if.sv
// Wishbone classic slave bundle between an initiator and wb_sram_responder.
// WB_SRAM_RESPONDER_ERR_EN adds the wbs_err_o response line.
interface wb_sram_responder_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
`ifdef WB_SRAM_RESPONDER_ERR_EN
  logic        wbs_err_o;
`endif

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
`ifdef WB_SRAM_RESPONDER_ERR_EN
    input  wbs_err_o,
`endif
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
`ifdef WB_SRAM_RESPONDER_ERR_EN
    output wbs_err_o,
`endif
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_sram_responder.sv
// Wishbone classic responder driving port 0 of a sky130 1rw1r 32x512 SRAM macro.
// Optional WB_SRAM_RESPONDER_ERR_EN: address decode against BASE_ADDR with error response.
module wb_sram_responder #(
  parameter logic [31:0] BASE_ADDR        = 32'h3000_0000,
  parameter int unsigned ADDR_WIDTH_WORDS = 9
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rstn_i,
  wb_sram_responder_if.slave          wbs,
  output logic                        sram_clk0,
  output logic                        sram_csb0,
  output logic                        sram_web0,
  output logic [3:0]                  sram_wmask0,
  output logic [ADDR_WIDTH_WORDS-1:0] sram_addr0,
  output logic [31:0]                 sram_din0,
  input  logic [31:0]                 sram_dout0
);

`ifdef WB_SRAM_RESPONDER_ERR_EN
  typedef enum logic [1:0] {IDLE, RD, ACK, ERR} state_t;
`else
  typedef enum logic [1:0] {IDLE, RD, ACK} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] dat_q, dat_d;
  logic        hit;
  logic        req;
  logic        unused_bits;

  // Byte-offset bits and (when undecoded) the upper address bits are don't-cares.
  assign unused_bits = ^{wbs.wbs_adr_i[31:ADDR_WIDTH_WORDS+2], wbs.wbs_adr_i[1:0], BASE_ADDR};

`ifdef WB_SRAM_RESPONDER_ERR_EN
  assign hit = (wbs.wbs_adr_i[31:ADDR_WIDTH_WORDS+2] == BASE_ADDR[31:ADDR_WIDTH_WORDS+2]);
`else
  assign hit = 1'b1;
`endif

  assign req = wbs.wbs_cyc_i & wbs.wbs_stb_i & hit;

  assign sram_clk0  = wb_clk_i;
  assign sram_addr0 = wbs.wbs_adr_i[ADDR_WIDTH_WORDS+1:2];
  assign sram_din0  = wbs.wbs_dat_i;

  always_comb begin
    state_d     = state_q;
    dat_d       = dat_q;
    sram_csb0   = 1'b1;
    sram_web0   = 1'b1;
    sram_wmask0 = '0;
    case (state_q)
      IDLE: begin
        if (req) begin
          // Macro samples these on the next edge, so they are driven straight from the bus.
          sram_csb0   = 1'b0;
          sram_web0   = ~wbs.wbs_we_i;
          sram_wmask0 = wbs.wbs_we_i ? wbs.wbs_sel_i : 4'b0000;
          state_d     = wbs.wbs_we_i ? ACK : RD;
        end
`ifdef WB_SRAM_RESPONDER_ERR_EN
        else if (wbs.wbs_cyc_i && wbs.wbs_stb_i) begin
          state_d = ERR;
        end
`endif
      end
      RD: begin
        if (wbs.wbs_cyc_i) begin
          dat_d   = sram_dout0;
          state_d = ACK;
        end else begin
          state_d = IDLE;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rstn_i) begin
      state_q <= IDLE;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
    end
  end

  assign wbs.wbs_ack_o = (state_q == ACK);
  assign wbs.wbs_dat_o = dat_q;
`ifdef WB_SRAM_RESPONDER_ERR_EN
  assign wbs.wbs_err_o = (state_q == ERR);
`endif

endmodule

// File: tb/tb_wb_sram_responder.sv
// Directed plus randomized bench for wb_sram_responder with a behavioural SRAM and memory model.
module tb_wb_sram_responder;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int unsigned AW   = 9;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  wb_sram_responder_if bus();

  logic          sram_clk0, csb0, web0;
  logic [3:0]    wmask0;
  logic [AW-1:0] addr0;
  logic [31:0]   din0;
  logic [31:0]   dout0 = '0;

  wb_sram_responder #(.BASE_ADDR(BASE), .ADDR_WIDTH_WORDS(AW)) dut (
    .wb_clk_i   (clk),
    .wb_rstn_i  (rstn),
    .wbs        (bus.slave),
    .sram_clk0  (sram_clk0),
    .sram_csb0  (csb0),
    .sram_web0  (web0),
    .sram_wmask0(wmask0),
    .sram_addr0 (addr0),
    .sram_din0  (din0),
    .sram_dout0 (dout0)
  );

  // Macro stand-in: synchronous port 0, read data appears after the sampling edge.
  logic [31:0] sram_mem [512];
  always @(posedge sram_clk0) begin
    if (!csb0) begin
      if (!web0) begin
        if (wmask0[0]) sram_mem[addr0][7:0]   <= din0[7:0];
        if (wmask0[1]) sram_mem[addr0][15:8]  <= din0[15:8];
        if (wmask0[2]) sram_mem[addr0][23:16] <= din0[23:16];
        if (wmask0[3]) sram_mem[addr0][31:24] <= din0[31:24];
      end else begin
        dout0 <= sram_mem[addr0];
      end
    end
  end

  logic [31:0] ref_mem [512];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  task automatic ref_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    int unsigned w;
    w = (adr >> 2) % 512;
    ref_mem[w] = (ref_mem[w] & ~byte_mask(sel)) | (dat & byte_mask(sel));
  endtask

  task automatic bus_idle();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
  endtask

  task automatic bus_drive(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    bus.wbs_sel_i = sel;
  endtask

  // One complete transfer; checks strobe-cycle macro controls, latency, read data and ack width.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdat);
    int n;
    int unsigned w;
    w = (adr >> 2) % 512;
    @(posedge clk); #1;
    bus_drive(we, adr, dat, sel);
    #1;
    chk("csb0_strobe", {31'b0, csb0}, 32'd0);
    chk("web0_strobe", {31'b0, web0}, {31'b0, ~we});
    chk("wmask0_strobe", {28'b0, wmask0}, we ? {28'b0, sel} : 32'd0);
    chk("addr0_strobe", {23'b0, addr0}, w);
    chk("ack_in_strobe", {31'b0, bus.wbs_ack_o}, 32'd0);
    if (we) chk("din0_strobe", din0, dat);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.wbs_ack_o && n < 10);
    chk(we ? "write_latency" : "read_latency", n, we ? 32'd1 : 32'd2);
    rdat = bus.wbs_dat_o;
    bus_idle();
    if (we) ref_write(adr, dat, sel);
    else    chk("read_data", rdat, ref_mem[w]);
    @(posedge clk); #1;
    chk("ack_one_cycle", {31'b0, bus.wbs_ack_o}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [5:0]  csb_vec, ack_vec;
    logic [31:0] d2, d5;
    int n;

    for (int i = 0; i < 512; i++) begin
      sram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    bus_idle();
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'b0, bus.wbs_ack_o}, 32'd0);
    chk("rst_dat", bus.wbs_dat_o, 32'd0);
    chk("rst_csb0", {31'b0, csb0}, 32'd1);
    chk("rst_web0", {31'b0, web0}, 32'd1);
    chk("rst_wmask0", {28'b0, wmask0}, 32'd0);
    chk("sram_clk0", {31'b0, sram_clk0}, {31'b0, clk});
`ifdef WB_SRAM_RESPONDER_ERR_EN
    chk("rst_err", {31'b0, bus.wbs_err_o}, 32'd0);
`endif
    rstn = 1'b1;

    wb_xfer(1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, rd);
    wb_xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, rd);
    chk("read_deadbeef", rd, 32'hDEAD_BEEF);

    wb_xfer(1'b1, 32'h3000_0020, 32'hAABB_CCDD, 4'hF, rd);
    wb_xfer(1'b1, 32'h3000_0020, 32'h1122_3344, 4'b0101, rd);
    wb_xfer(1'b0, 32'h3000_0020, 32'h0, 4'hF, rd);
    chk("read_partial", rd, 32'hAA22_CC44);

    wb_xfer(1'b1, 32'h3000_0020, 32'hFFFF_FFFF, 4'h0, rd);
    wb_xfer(1'b0, 32'h3000_0020, 32'h0, 4'hF, rd);
    chk("read_after_sel0", rd, 32'hAA22_CC44);

    // Back-to-back reads, strobe held through ack; address advances during ack.
    @(posedge clk); #1;
    bus_drive(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    d2 = '0;
    d5 = '0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      #1;
      csb_vec[i] = ~csb0;
      ack_vec[i] = bus.wbs_ack_o;
      if (i == 2) d2 = bus.wbs_dat_o;
      if (i == 5) d5 = bus.wbs_dat_o;
      if (bus.wbs_ack_o) bus.wbs_adr_i = 32'h3000_0020;
      if (i == 5) bus_idle();
    end
    chk("b2b_csb_pattern", {26'b0, csb_vec}, 32'b001001);
    chk("b2b_ack_pattern", {26'b0, ack_vec}, 32'b100100);
    chk("b2b_data0", d2, 32'hDEAD_BEEF);
    chk("b2b_data1", d5, 32'hAA22_CC44);

    // Abort during RD, then a write in the very next cycle.
    @(posedge clk); #1;
    bus_drive(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    @(posedge clk); #1;
    bus_idle();
    @(posedge clk); #1;
    chk("abort_no_ack", {31'b0, bus.wbs_ack_o}, 32'd0);
    chk("abort_dat_held", bus.wbs_dat_o, 32'hAA22_CC44);
    bus_drive(1'b1, 32'h3000_0030, 32'h0055_AA00, 4'hF);
    #1;
    chk("abort_then_csb0", {31'b0, csb0}, 32'd0);
    @(posedge clk); #1;
    chk("abort_then_ack", {31'b0, bus.wbs_ack_o}, 32'd1);
    bus_idle();
    ref_write(32'h3000_0030, 32'h0055_AA00, 4'hF);
    wb_xfer(1'b0, 32'h3000_0030, 32'h0, 4'hF, rd);

    // Reset asserted while a read is being acknowledged.
    @(posedge clk); #1;
    bus_drive(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.wbs_ack_o && n < 10);
    chk("rst_ack_seen", {31'b0, bus.wbs_ack_o}, 32'd1);
    chk("rst_ack_dat", bus.wbs_dat_o, 32'hDEAD_BEEF);
    rstn = 1'b0;
    bus_idle();
    @(posedge clk); #1;
    chk("midrst_ack", {31'b0, bus.wbs_ack_o}, 32'd0);
    chk("midrst_dat", bus.wbs_dat_o, 32'd0);
    chk("midrst_csb0", {31'b0, csb0}, 32'd1);
    rstn = 1'b1;
    wb_xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, rd);

`ifdef WB_SRAM_RESPONDER_ERR_EN
    @(posedge clk); #1;
    bus_drive(1'b0, 32'h3000_4000, 32'h0, 4'hF);
    #1;
    chk("err_csb0", {31'b0, csb0}, 32'd1);
    @(posedge clk); #1;
    chk("err_asserted", {31'b0, bus.wbs_err_o}, 32'd1);
    chk("err_no_ack", {31'b0, bus.wbs_ack_o}, 32'd0);
    bus_idle();
    @(posedge clk); #1;
    chk("err_one_cycle", {31'b0, bus.wbs_err_o}, 32'd0);
    chk("err_no_ack_after", {31'b0, bus.wbs_ack_o}, 32'd0);
`endif

    // Random traffic; with decode disabled the upper address bits are free (aliasing).
    for (int i = 0; i < 60; i++) begin
      logic [20:0] hi;
      logic [8:0]  word;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] dat;
      hi   = 21'($urandom);
`ifdef WB_SRAM_RESPONDER_ERR_EN
      hi   = BASE[31:11];
`endif
      word = 9'($urandom_range(0, 15));
      we   = 1'($urandom_range(0, 1));
      sel  = 4'($urandom);
      dat  = $urandom;
      wb_xfer(we, {hi, word, 2'($urandom)}, dat, sel, rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_sram_responder.md
Name: wb_sram_responder

Overview:
Wishbone classic responder that fronts one sky130_sram_2kbyte_1rw1r_32x512_8 macro on its port 0 (clk0/csb0/web0/wmask0/addr0/din0/dout0). It lets the Caravel management Wishbone bus, or the rvj1 SoC data bus, read and write IRAM/DRAM directly. It generates the chip select, write enable and byte mask, captures read data and produces the ack. It sits between a Wishbone initiator and the SRAM macro in user_project_wrapper.

Parameters:
BASE_ADDR, 32'h3000_0000, byte base address of the window served by this instance.
ADDR_WIDTH_WORDS, 9, word address width of the macro (512 words).

Ports:
wb_clk_i  input  1  clock; also forwarded to the macro.
wb_rstn_i  input  1  synchronous active-low reset.
wbs_cyc_i  input  1  Wishbone cycle.
wbs_stb_i  input  1  Wishbone strobe.
wbs_we_i  input  1  1 = write.
wbs_sel_i  input  4  byte lane select.
wbs_adr_i  input  32  byte address.
wbs_dat_i  input  32  write data.
wbs_ack_o  output  1  transfer acknowledge.
wbs_dat_o  output  32  read data.
sram_clk0  output  1  equal to wb_clk_i.
sram_csb0  output  1  chip select, active low.
sram_web0  output  1  write enable, active low.
sram_wmask0  output  4  byte write mask.
sram_addr0  output  ADDR_WIDTH_WORDS  word address, equal to wbs_adr_i[ADDR_WIDTH_WORDS+1:2].
sram_din0  output  32  write data, equal to wbs_dat_i.
sram_dout0  input  32  macro read data.

Interface clocking: one clock; reset is synchronous and active-low (wb_clk_i, wb_rstn_i).

Behaviour:
- FSM states: IDLE, RD, ACK. Reset (wb_rstn_i=0 at a rising edge) gives: state IDLE, wbs_ack_o=0, wbs_dat_o=0. sram_csb0 is 1 whenever state is not IDLE.
- req = wbs_cyc_i & wbs_stb_i & hit. Without the optional feature, hit=1.
- IDLE with req: macro controls driven combinationally in the same cycle.
  - sram_csb0=0.
  - sram_web0=~wbs_we_i.
  - sram_wmask0=wbs_sel_i on writes, 4'b0000 on reads.
  - The macro samples on the next rising edge.
  - Write: next state ACK.
  - Read: next state RD.
- IDLE without req: sram_csb0=1, sram_web0=1, sram_wmask0=0; stay in IDLE.
- RD: sram_dout0 is valid; register it into wbs_dat_o at the end of the cycle.
  - Next state ACK if wbs_cyc_i=1.
  - If wbs_cyc_i=0 (initiator abort): next state IDLE, no ack, wbs_dat_o unchanged.
- ACK: wbs_ack_o=1 for exactly one cycle; wbs_dat_o holds the read data (stale after a write). Next state is always IDLE.
- Requests present during ACK are ignored. A new request is accepted in the following IDLE cycle, so sustained throughput is one transfer per 2 cycles for writes and per 3 cycles for reads.
- Latency, strobe-first-seen to ack: write 1 cycle, read 2 cycles.
- wbs_sel_i=0 on a write: macro still selected with wmask 0, memory unchanged, ack given.
- Reset mid-transfer: the FSM returns to IDLE immediately and no ack is issued. A write already sampled by the macro completes.
- Address wrap: bits above ADDR_WIDTH_WORDS+1 are ignored when the feature is off, so addresses alias modulo 2 KiB.

Optional Feature:
Macro WB_SRAM_RESPONDER_ERR_EN.
- Defined:
  - Adds output wbs_err_o (1 bit, reset 0).
  - hit = (wbs_adr_i[31:ADDR_WIDTH_WORDS+2] == BASE_ADDR[31:ADDR_WIDTH_WORDS+2]).
  - A cyc&stb with hit=0 in IDLE keeps sram_csb0=1 and moves to an ERR state. ERR asserts wbs_err_o for one cycle with wbs_ack_o=0, then returns to IDLE.
- Undefined: no wbs_err_o port, hit=1, addresses alias as above.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x3000_0010 with sel=4'hF. Expect: csb0=0, web0=0, addr0=4 in the strobe cycle; ack exactly 1 cycle later. Read 0x3000_0010 and expect ack 2 cycles after strobe with wbs_dat_o=0xDEADBEEF.
- Write 0x11223344 with sel=4'b0101 over a word holding 0xAABBCCDD. Expect wmask0=4'b0101; readback 0xAA22CC44.
- Back-to-back reads with stb held high across ack. Expect a second csb0=0 only one cycle after ack, and acks spaced 3 cycles apart.
- Drop cyc during RD. Expect no ack, state IDLE next cycle; a following write still acks after 1 cycle.
- Assert wb_rstn_i=0 during ACK. Expect ack=0 and wbs_dat_o=0 next cycle, csb0=1.
- With WB_SRAM_RESPONDER_ERR_EN defined, read 0x3000_4000 on an instance with BASE_ADDR=0x3000_0000. Expect wbs_err_o=1 for 1 cycle, csb0 stays 1, no ack.
